// File: rtl/store_commit_buffer.sv
// store_commit_buffer
//   Post-commit store buffer. Retired stores are queued in a circular FIFO and
//   drained in order to data memory through a req/ready + ack handshake. Stores
//   stay forwardable to younger loads until memory acknowledges them.
//
//   Optional feature macro: STORE_FWD_EN
//     defined   : address comparators + youngest-match forwarding
//     undefined : fwd_hit/fwd_data tied to 0, fwd_valid/fwd_addr unused
//
//   Ports
//     clk, reset                         clock, async active-high reset
//     commit_valid/addr/data, commit_ready   retiring store input
//     mem_req_valid/addr/data, mem_req_ready write request to memory
//     mem_ack                            accepted write has completed
//     fwd_valid/addr, fwd_hit/data       combinational load lookup
//     sb_full, sb_empty, sb_count        occupancy (registered count)
module store_commit_buffer #(
  parameter int SB_DEPTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      commit_valid,
  input  logic [ADDR_WIDTH-1:0]     commit_addr,
  input  logic [DATA_WIDTH-1:0]     commit_data,
  output logic                      commit_ready,
  output logic                      mem_req_valid,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [DATA_WIDTH-1:0]     mem_req_data,
  input  logic                      mem_req_ready,
  input  logic                      mem_ack,
  input  logic                      fwd_valid,
  input  logic [ADDR_WIDTH-1:0]     fwd_addr,
  output logic                      fwd_hit,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic                      sb_full,
  output logic                      sb_empty,
  output logic [$clog2(SB_DEPTH):0] sb_count
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

  state_t                              state_q;
  logic                                req_vld_q;
  logic [PTR_W-1:0]                    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                    count_q, count_d;
  logic [SB_DEPTH-1:0]                 vld_q;
  logic [SB_DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [SB_DEPTH-1:0][DATA_WIDTH-1:0] data_q;

  logic push, pop;

  // Full is taken from the registered count, so a same-cycle pop never
  // frees a slot for a push.
  assign sb_full      = (count_q == CNT_W'(SB_DEPTH));
  assign sb_empty     = (count_q == '0);
  assign sb_count     = count_q;
  assign commit_ready = ~sb_full;

  assign push = commit_valid & commit_ready;
  assign pop  = (state_q == WAIT_ACK) & mem_ack;

  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // push and pop never target the same slot: pop needs count>0 and
      // push needs count<DEPTH, so tail==head implies at most one of them.
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        addr_q[tail_q] <= commit_addr;
        data_q[tail_q] <= commit_data;
      end
      if (pop) vld_q[head_q] <= 1'b0;
    end
  end

  // Drain FSM; req_vld_q is the registered image of state==SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (count_q != '0) begin
          state_q   <= SEND;
          req_vld_q <= 1'b1;
        end
        SEND: if (mem_req_ready) begin
          state_q   <= WAIT_ACK;
          req_vld_q <= 1'b0;
        end
        WAIT_ACK: if (mem_ack) begin
          // count_q is the pre-pop value here.
          if (count_q > CNT_W'(1)) begin
            state_q   <= SEND;
            req_vld_q <= 1'b1;
          end else begin
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          req_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid = req_vld_q;
  assign mem_req_addr  = req_vld_q ? addr_q[head_q] : '0;
  assign mem_req_data  = req_vld_q ? data_q[head_q] : '0;

`ifdef STORE_FWD_EN
  // Walk oldest->youngest from head; later matches override, so the result
  // is the youngest matching store.
  logic [PTR_W-1:0] fwd_idx;
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (fwd_valid) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        fwd_idx = head_q + PTR_W'(i);
        if (vld_q[fwd_idx] && (addr_q[fwd_idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[fwd_idx];
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_addr};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule
